// File: rtl/output_ctrl_rr.sv
// rtl/output_ctrl_rr.sv - N-input packet FIFO bank with round-robin/fixed-priority arbitration into one output register
module output_ctrl_rr #(
    parameter int WIDTH_packet = 14,
    parameter int NUM_IN       = 2,
    parameter int DEPTH        = 4,
    parameter int PRIO_MODE    = 0
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [NUM_IN-1:0]                                 in_valid,
    output logic [NUM_IN-1:0]                                 in_ready,
    input  logic [NUM_IN*WIDTH_packet-1:0]                    in_data,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [WIDTH_packet-1:0]                           out_data,
    output logic [((NUM_IN > 1) ? $clog2(NUM_IN) : 1)-1:0]    out_src
);

    localparam int W  = WIDTH_packet;
    localparam int SW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] C_DEPTH = (PW+1)'(DEPTH);

    logic [NUM_IN-1:0] w_nonempty;
    logic [W-1:0]      w_head [NUM_IN];
    logic              w_load;
    logic              w_found;
    logic [SW-1:0]     w_gidx;
    logic              w_pop_any;
    int                w_start;

    logic              r_out_valid;
    logic [W-1:0]      r_out_data;
    logic [SW-1:0]     r_out_src;
    logic [SW-1:0]     r_rr_ptr;

    assign w_load    = !r_out_valid || out_ready;
    assign w_pop_any = w_load && w_found;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_fifo
        logic [W-1:0]  r_mem [DEPTH];
        logic [PW-1:0] r_wr_ptr;
        logic [PW-1:0] r_rd_ptr;
        logic [PW:0]   r_count;
        logic          w_push;
        logic          w_pop;

        // Ready comes from registered count only, so a full FIFO stays closed even while it is popped
        assign in_ready[gi]   = !rst && (r_count < C_DEPTH);
        assign w_push         = in_valid[gi] && in_ready[gi];
        assign w_pop          = w_pop_any && (w_gidx == SW'(gi));
        assign w_nonempty[gi] = (r_count != '0);
        assign w_head[gi]     = r_mem[r_rd_ptr];

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data[gi*W +: W];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (PW+1)'(1);
                    2'b01:   r_count <= r_count - (PW+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Two passes: indices at/after the start point first, then the wrapped-around ones
    always_comb begin
        w_start = (PRIO_MODE != 0) ? 0 : int'(r_rr_ptr);
        w_found = 1'b0;
        w_gidx  = '0;
        for (int j = 0; j < NUM_IN; j++) begin
            if (!w_found && w_nonempty[j] && (j >= w_start)) begin
                w_found = 1'b1;
                w_gidx  = SW'(j);
            end
        end
        for (int j = 0; j < NUM_IN; j++) begin
            if (!w_found && w_nonempty[j] && (j < w_start)) begin
                w_found = 1'b1;
                w_gidx  = SW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            if (w_found) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_head[w_gidx];
                r_out_src   <= w_gidx;
                if (PRIO_MODE == 0) begin
                    r_rr_ptr <= (w_gidx == SW'(NUM_IN-1)) ? '0 : w_gidx + SW'(1);
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: doc/output_ctrl_rr.md
OUTPUT_CTRL_RR -- requirements
Module: output_ctrl_rr

Interface
REQ-001 The block SHALL have parameter WIDTH_packet, default 14: packet width in bits.
REQ-002 The block SHALL have parameter NUM_IN, default 2, legal range 2..8: number of input ports.
REQ-003 The block SHALL have parameter DEPTH, default 4, power of two, at least 2: per-input FIFO depth in packets.
REQ-004 The block SHALL have parameter PRIO_MODE, default 0: 0 = round-robin arbitration, 1 = fixed priority with the lowest index winning.
REQ-005 The block SHALL have ports clk (input, 1 bit: the single clock, rising-edge) and rst (input, 1 bit: synchronous, active-high reset); the block has one clock and rst is sampled only on the rising clk edge.
REQ-006 The block SHALL have port in_valid (input, NUM_IN bits): per-input packet present.
REQ-007 The block SHALL have port in_ready (output, NUM_IN bits): per-input FIFO can accept.
REQ-008 The block SHALL have port in_data (input, NUM_IN*WIDTH_packet bits): input i occupies bits [i*WIDTH_packet +: WIDTH_packet].
REQ-009 The block SHALL have port out_valid (output, 1 bit): output register holds a packet.
REQ-010 The block SHALL have port out_ready (input, 1 bit): downstream accepts the packet.
REQ-011 The block SHALL have port out_data (output, WIDTH_packet bits): the granted packet.
REQ-012 The block SHALL have port out_src (output, max(1,$clog2(NUM_IN)) bits): index of the input the current out_data came from.

Function
REQ-013 The block SHALL transfer an input packet only on a rising edge where in_valid[i] && in_ready[i] is true; that packet is written to FIFO i.
REQ-014 The block SHALL drive in_ready[i] = !rst && (count_i < DEPTH) from registered state only, with no same-cycle pop bypass; a full FIFO refuses a push even in a cycle where it is popped.
REQ-015 The block SHALL hold each FIFO as a circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0, plus a count of $clog2(DEPTH)+1 bits.
REQ-016 The block SHALL treat the output register as able to load when out_valid==0 or (out_valid && out_ready).
REQ-017 On an edge where the output register can load and at least one FIFO is non-empty, the block SHALL pop exactly one FIFO (the arbitration winner), load its head into out_data, set out_src to its index, and set out_valid=1.
REQ-018 On an edge where the output register can load and all FIFOs are empty, the block SHALL clear out_valid to 0; out_data and out_src keep their last values.
REQ-019 When out_valid && !out_ready, the block SHALL hold out_valid, out_data and out_src stable.
REQ-020 The block SHALL give a minimum latency of 2 edges: a packet pushed at edge N into an empty FIFO, with an idle output, appears on out_data with out_valid=1 after edge N+1.
REQ-021 The block SHALL sustain a throughput of one packet per cycle when out_ready is held high and any FIFO is non-empty.
REQ-022 In round-robin mode (PRIO_MODE=0), the block SHALL keep a pointer rr_ptr; search order is rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_IN; the first non-empty FIFO wins.
REQ-023 In round-robin mode, after a grant to input g the block SHALL set rr_ptr to (g+1) mod NUM_IN; rr_ptr is unchanged when there is no grant.
REQ-024 In fixed-priority mode (PRIO_MODE=1), the block SHALL grant the lowest-index non-empty FIFO and SHALL ignore rr_ptr.
REQ-025 The block SHALL allow a push and a pop on the same FIFO in the same edge; count is unchanged and the data order is preserved.
REQ-026 The block SHALL never reorder packets from a single input and SHALL never drop or duplicate packets.
REQ-027 The block SHALL have total storage per input of DEPTH packets, plus one shared output register.

Reset
REQ-028 While rst=1 at a rising edge, the block SHALL empty all FIFOs, set all pointers and counts to 0, and set out_valid=0, out_data=0, out_src=0 and rr_ptr=0.
REQ-029 While rst=1, the block SHALL hold in_ready at all zeros; it SHALL accept no push and perform no pop.
REQ-030 On a reset asserted mid-operation, the block SHALL discard all buffered and in-flight packets; the first packet accepted after rst deasserts follows REQ-020 latency.

Verification
REQ-031 Scenario, single packet: in0 pushes 14'h2820 at edge 1, out_ready=1 -> after edge 2, out_valid=1, out_data=14'h2820, out_src=0; after edge 3, out_valid=0.
REQ-032 Scenario, simultaneous round-robin: PRIO_MODE=0 after reset; in0=14'h1ABE and in1=14'h313E pushed at the same edge; out_ready=1 -> outputs are 14'h1ABE/src 0, then 14'h313E/src 1 on consecutive cycles.
REQ-033 Scenario, fairness: NUM_IN=2, both FIFOs kept non-empty, out_ready=1 for 8 cycles -> out_src sequence is 0,1,0,1,0,1,0,1.
REQ-034 Scenario, backpressure and full: DEPTH=4, out_ready=0, in0 pushes continuously -> exactly 5 packets accepted, in_ready[0]=0 afterwards, out_data holds the first packet stable; raising out_ready drains all 5 in order.
REQ-035 Scenario, fixed priority: PRIO_MODE=1, in0 and in1 both continuously valid -> every grant has out_src=0 while FIFO 0 is non-empty; in1 is served only when FIFO 0 is empty.
REQ-036 Scenario, reset mid-operation: FIFOs hold 3 packets each with out_valid=1; assert rst for one edge -> out_valid=0, in_ready=0 during rst; after release, no stale packet ever appears on the output.
